// File: rtl/pf_sched_pkg.sv
// Purpose    : shared types and defaults for the prefetch slot scheduler.
// Latency    : n/a (declarations only).
// Backpressure: n/a.
// Contents   : slot_state_e per-slot lifecycle encoding, default slot count and address width.
package pf_sched_pkg;

  typedef enum logic [1:0] {
    SLOT_FREE = 2'b00,
    SLOT_PEND = 2'b01,
    SLOT_INFL = 2'b10
  } slot_state_e;

  localparam int PF_SLOT_NUM = 8;
  localparam int PF_ADDR_W   = 64;

endpackage

// File: rtl/highbit.sv
// Purpose    : index of the highest set bit of vec; MSB of idx set when vec is all zero.
// Latency    : combinational.
// Backpressure: n/a.
// Ports      : vec (IN_WIDTH) in; idx (OUT_WIDTH) out, low bits = index, top bit = none found.
module highbit #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 4
) (
  input  logic [IN_WIDTH-1:0]  vec,
  output logic [OUT_WIDTH-1:0] idx
);

  // Scan upward so the last hit, i.e. the highest set bit, wins.
  always_comb begin
    idx = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (vec[i]) idx = OUT_WIDTH'(i);
    end
  end

endmodule

// File: rtl/pf_slot_scheduler.sv
// Purpose    : tracks outstanding prefetches in SLOT_NUM slots, issues them round-robin, frees on done.
// Latency    : alloc at edge N -> earliest issue_valid after edge N+1; done at edge M -> slot allocatable in cycle M+1.
// Backpressure: alloc_ready low when no slot is free; issue register holds until issue_ready.
// Ports      : clk, resetN (sync, active low); alloc_valid/addr/ready/slot; issue_valid/ready/addr/slot;
//              done_valid/slot; busy_cnt (non-free slots); err (sticky, done on a slot not in flight).
module pf_slot_scheduler
  import pf_sched_pkg::*;
#(
  parameter int SLOT_NUM   = PF_SLOT_NUM,
  parameter int SLOT_IDX_W = $clog2(SLOT_NUM),
  parameter int ADDR_W     = PF_ADDR_W
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  alloc_valid,
  input  logic [ADDR_W-1:0]     alloc_addr,
  output logic                  alloc_ready,
  output logic [SLOT_IDX_W-1:0] alloc_slot,
  output logic                  issue_valid,
  input  logic                  issue_ready,
  output logic [ADDR_W-1:0]     issue_addr,
  output logic [SLOT_IDX_W-1:0] issue_slot,
  input  logic                  done_valid,
  input  logic [SLOT_IDX_W-1:0] done_slot,
  output logic [SLOT_IDX_W:0]   busy_cnt,
  output logic                  err
);

  localparam int CNT_W = SLOT_IDX_W + 1;

  slot_state_e             slot_st  [SLOT_NUM];
  logic [ADDR_W-1:0]       addr_mem [SLOT_NUM];
  logic [SLOT_IDX_W-1:0]   rr_ptr;

  logic [SLOT_NUM-1:0]     free_vec;
  logic [SLOT_NUM-1:0]     pend_vec;
  logic [SLOT_NUM-1:0]     below_rr;
  logic [CNT_W-1:0]        free_pick;
  logic [CNT_W-1:0]        pend_pick_masked;
  logic [CNT_W-1:0]        pend_pick_all;

  logic                    pend_any;
  logic [SLOT_IDX_W-1:0]   issue_sel;
  logic                    issue_load;
  logic                    alloc_fire;
  logic                    done_ok;
  logic [CNT_W-1:0]        busy_nxt;

  always_comb begin
    free_vec = '0;
    pend_vec = '0;
    below_rr = '0;
    for (int i = 0; i < SLOT_NUM; i++) begin
      free_vec[i] = (slot_st[i] == SLOT_FREE);
      pend_vec[i] = (slot_st[i] == SLOT_PEND);
      below_rr[i] = (SLOT_IDX_W'(i) < rr_ptr);
    end
  end

  highbit #(.IN_WIDTH(SLOT_NUM), .OUT_WIDTH(CNT_W)) u_free_pick (
    .vec (free_vec),
    .idx (free_pick)
  );

  highbit #(.IN_WIDTH(SLOT_NUM), .OUT_WIDTH(CNT_W)) u_pend_pick_masked (
    .vec (pend_vec & below_rr),
    .idx (pend_pick_masked)
  );

  highbit #(.IN_WIDTH(SLOT_NUM), .OUT_WIDTH(CNT_W)) u_pend_pick_all (
    .vec (pend_vec),
    .idx (pend_pick_all)
  );

  // MSB clear on the free pick is the same as "some slot is free".
  assign alloc_ready = ~free_pick[CNT_W-1];
  assign alloc_slot  = free_pick[SLOT_IDX_W-1:0];
  assign alloc_fire  = alloc_valid & alloc_ready;

  // Prefer the highest pending slot below the last issued one; wrap to the top when none.
  assign pend_any   = ~pend_pick_all[CNT_W-1];
  assign issue_sel  = pend_pick_masked[CNT_W-1] ? pend_pick_all[SLOT_IDX_W-1:0]
                                                : pend_pick_masked[SLOT_IDX_W-1:0];
  assign issue_load = (~issue_valid | issue_ready) & pend_any;

  assign done_ok = done_valid & (slot_st[done_slot] == SLOT_INFL);

  always_comb begin
    busy_nxt = busy_cnt;
    if (alloc_fire) busy_nxt = busy_nxt + CNT_W'(1);
    if (done_ok)    busy_nxt = busy_nxt - CNT_W'(1);
  end

  // Alloc, issue-load and done each touch a slot in a different state, so the
  // three indexed writes below never collide.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      for (int i = 0; i < SLOT_NUM; i++) begin
        slot_st[i]  <= SLOT_FREE;
        addr_mem[i] <= '0;
      end
      rr_ptr      <= '0;
      issue_valid <= 1'b0;
      issue_addr  <= '0;
      issue_slot  <= '0;
      busy_cnt    <= '0;
      err         <= 1'b0;
    end else begin
      if (alloc_fire) begin
        slot_st[alloc_slot]  <= SLOT_PEND;
        addr_mem[alloc_slot] <= alloc_addr;
      end
      if (issue_load) begin
        slot_st[issue_sel] <= SLOT_INFL;
        rr_ptr             <= issue_sel;
        issue_valid        <= 1'b1;
        issue_addr         <= addr_mem[issue_sel];
        issue_slot         <= issue_sel;
      end else if (issue_ready) begin
        issue_valid <= 1'b0;
      end
      if (done_ok) begin
        slot_st[done_slot] <= SLOT_FREE;
      end else if (done_valid) begin
        err <= 1'b1;
      end
      busy_cnt <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_pf_slot_scheduler.sv
// Purpose    : self-checking bench for pf_slot_scheduler (table of per-edge vectors plus corner sequences).
// Latency    : outputs sampled 1 time unit after each rising edge.
// Backpressure: issue_ready driven per vector.
module tb_pf_slot_scheduler;
  import pf_sched_pkg::*;

  localparam int SLOT_NUM   = 8;
  localparam int SLOT_IDX_W = 3;
  localparam int ADDR_W     = 64;

  logic                  clk = 1'b0;
  logic                  resetN;
  logic                  alloc_valid;
  logic [ADDR_W-1:0]     alloc_addr;
  logic                  alloc_ready;
  logic [SLOT_IDX_W-1:0] alloc_slot;
  logic                  issue_valid;
  logic                  issue_ready;
  logic [ADDR_W-1:0]     issue_addr;
  logic [SLOT_IDX_W-1:0] issue_slot;
  logic                  done_valid;
  logic [SLOT_IDX_W-1:0] done_slot;
  logic [SLOT_IDX_W:0]   busy_cnt;
  logic                  err;

  always #5 clk = ~clk;

  pf_slot_scheduler #(
    .SLOT_NUM   (SLOT_NUM),
    .SLOT_IDX_W (SLOT_IDX_W),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk         (clk),
    .resetN      (resetN),
    .alloc_valid (alloc_valid),
    .alloc_addr  (alloc_addr),
    .alloc_ready (alloc_ready),
    .alloc_slot  (alloc_slot),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_addr  (issue_addr),
    .issue_slot  (issue_slot),
    .done_valid  (done_valid),
    .done_slot   (done_slot),
    .busy_cnt    (busy_cnt),
    .err         (err)
  );

  typedef struct {
    logic        av;
    logic [63:0] aa;
    logic        ir;
    logic        dv;
    logic [2:0]  ds;
    logic        ar;
    logic [2:0]  as;
    logic        iv;
    logic [2:0]  is;
    logic [63:0] ia;
    logic [3:0]  busy;
    logic        err;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic av, input logic [63:0] aa, input logic ir,
                              input logic dv, input logic [2:0] ds, input logic ar,
                              input logic [2:0] as, input logic iv, input logic [2:0] is,
                              input logic [63:0] ia, input logic [3:0] busy, input logic e);
    vec_t v;
    v.av = av; v.aa = aa; v.ir = ir; v.dv = dv; v.ds = ds;
    v.ar = ar; v.as = as; v.iv = iv; v.is = is; v.ia = ia; v.busy = busy; v.err = e;
    return v;
  endfunction

  task automatic drive(input logic av, input logic [63:0] aa, input logic ir,
                       input logic dv, input logic [2:0] ds);
    alloc_valid = av;
    alloc_addr  = aa;
    issue_ready = ir;
    done_valid  = dv;
    done_slot   = ds;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    drive(0, 64'h0, 0, 0, 3'd0);
    step();
    step();
    resetN = 1'b1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " alloc_ready"}, 64'(alloc_ready), 64'd1);
    chk({tag, " alloc_slot"},  64'(alloc_slot),  64'd7);
    chk({tag, " issue_valid"}, 64'(issue_valid), 64'd0);
    chk({tag, " issue_slot"},  64'(issue_slot),  64'd0);
    chk({tag, " issue_addr"},  issue_addr,       64'd0);
    chk({tag, " busy_cnt"},    64'(busy_cnt),    64'd0);
    chk({tag, " err"},         64'(err),         64'd0);
  endtask

  initial begin
    // Slot s is first allocated with address 0x100 + 0x10*(7-s).
    tbl.push_back(mk(1,'h100,0,0,0, 1,6,0,0,0,      1,0));  // 1 : slot 7 pending
    tbl.push_back(mk(1,'h110,0,0,0, 1,5,1,7,'h100,  2,0));  // 2 : 7 issued two edges after alloc
    tbl.push_back(mk(1,'h120,0,0,0, 1,4,1,7,'h100,  3,0));
    tbl.push_back(mk(1,'h130,0,0,0, 1,3,1,7,'h100,  4,0));
    tbl.push_back(mk(1,'h140,0,0,0, 1,2,1,7,'h100,  5,0));
    tbl.push_back(mk(1,'h150,0,0,0, 1,1,1,7,'h100,  6,0));
    tbl.push_back(mk(1,'h160,0,0,0, 1,0,1,7,'h100,  7,0));
    tbl.push_back(mk(1,'h170,0,0,0, 0,0,1,7,'h100,  8,0));  // 8 : full
    tbl.push_back(mk(1,'h999,0,0,0, 0,0,1,7,'h100,  8,0));  // 9 : alloc while full ignored
    tbl.push_back(mk(0,0,    1,0,0, 0,0,1,6,'h110,  8,0));  // 10: drain below rr_ptr
    tbl.push_back(mk(0,0,    1,0,0, 0,0,1,5,'h120,  8,0));
    tbl.push_back(mk(0,0,    1,0,0, 0,0,1,4,'h130,  8,0));
    tbl.push_back(mk(0,0,    1,0,0, 0,0,1,3,'h140,  8,0));
    tbl.push_back(mk(0,0,    1,0,0, 0,0,1,2,'h150,  8,0));
    tbl.push_back(mk(0,0,    1,0,0, 0,0,1,1,'h160,  8,0));
    tbl.push_back(mk(0,0,    1,0,0, 0,0,1,0,'h170,  8,0));  // 16: slot 0 held, rr_ptr=0
    tbl.push_back(mk(0,0,    0,1,7, 1,7,1,0,'h170,  7,0));  // 17: free 7,5,2
    tbl.push_back(mk(0,0,    0,1,5, 1,7,1,0,'h170,  6,0));
    tbl.push_back(mk(0,0,    0,1,2, 1,7,1,0,'h170,  5,0));
    tbl.push_back(mk(1,'hA07,0,0,0, 1,5,1,0,'h170,  6,0));  // 20: realloc 7,5,2 -> pending
    tbl.push_back(mk(1,'hA05,0,0,0, 1,2,1,0,'h170,  7,0));
    tbl.push_back(mk(1,'hA02,0,0,0, 0,0,1,0,'h170,  8,0));
    tbl.push_back(mk(0,0,    1,0,0, 0,0,1,7,'hA07,  8,0));  // 23: rr_ptr=0 -> wrap to 7
    tbl.push_back(mk(0,0,    1,0,0, 0,0,1,5,'hA05,  8,0));
    tbl.push_back(mk(0,0,    1,0,0, 0,0,1,2,'hA02,  8,0));
    tbl.push_back(mk(0,0,    1,1,7, 1,7,0,0,0,      7,0));  // 26: nothing pending, free 7
    tbl.push_back(mk(1,'hB07,1,0,0, 0,0,0,0,0,      8,0));
    tbl.push_back(mk(0,0,    1,0,0, 0,0,1,7,'hB07,  8,0));  // 28: nothing below 2 -> 7 again
    tbl.push_back(mk(0,0,    0,1,3, 1,3,1,7,'hB07,  7,0));  // 29: done on in-flight 3
    tbl.push_back(mk(0,0,    0,1,3, 1,3,1,7,'hB07,  7,1));  // 30: done on free 3 -> err
    tbl.push_back(mk(0,0,    0,0,0, 1,3,1,7,'hB07,  7,1));  // 31: err sticky

    do_reset();
    chk_reset_state("reset");

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].av, tbl[i].aa, tbl[i].ir, tbl[i].dv, tbl[i].ds);
      step();
      chk($sformatf("v%0d alloc_ready", i+1), 64'(alloc_ready), 64'(tbl[i].ar));
      if (tbl[i].ar)
        chk($sformatf("v%0d alloc_slot", i+1), 64'(alloc_slot), 64'(tbl[i].as));
      chk($sformatf("v%0d issue_valid", i+1), 64'(issue_valid), 64'(tbl[i].iv));
      if (tbl[i].iv) begin
        chk($sformatf("v%0d issue_slot", i+1), 64'(issue_slot), 64'(tbl[i].is));
        chk($sformatf("v%0d issue_addr", i+1), issue_addr, tbl[i].ia);
      end
      chk($sformatf("v%0d busy_cnt", i+1), 64'(busy_cnt), 64'(tbl[i].busy));
      chk($sformatf("v%0d err", i+1), 64'(err), 64'(tbl[i].err));
    end

    // Full table: done and alloc in the same cycle; the freed slot is only allocatable next cycle.
    do_reset();
    for (int k = 0; k < SLOT_NUM; k++) begin
      drive(1, 64'h200 + 64'(k), 1, 0, 3'd0);
      step();
    end
    drive(0, 64'h0, 1, 0, 3'd0);
    step();
    chk("full busy_cnt", 64'(busy_cnt), 64'd8);
    chk("full alloc_ready", 64'(alloc_ready), 64'd0);
    drive(1, 64'h444, 1, 1, 3'd0);
    step();
    chk("same-cycle busy_cnt", 64'(busy_cnt), 64'd7);
    chk("same-cycle alloc_ready", 64'(alloc_ready), 64'd1);
    chk("same-cycle alloc_slot", 64'(alloc_slot), 64'd0);
    chk("same-cycle issue_valid", 64'(issue_valid), 64'd0);
    drive(1, 64'h555, 0, 0, 3'd0);
    step();
    chk("next-cycle busy_cnt", 64'(busy_cnt), 64'd8);
    chk("next-cycle alloc_ready", 64'(alloc_ready), 64'd0);
    // Done on a pending slot sets err while the same slot is loaded for issue.
    drive(0, 64'h0, 0, 1, 3'd0);
    step();
    chk("pend-done err", 64'(err), 64'd1);
    chk("pend-done busy_cnt", 64'(busy_cnt), 64'd8);
    chk("realloc issue_valid", 64'(issue_valid), 64'd1);
    chk("realloc issue_slot", 64'(issue_slot), 64'd0);
    chk("realloc issue_addr", issue_addr, 64'h555);

    // Reset mid-operation with the issue register occupied; a concurrent alloc must not survive.
    resetN = 1'b0;
    drive(1, 64'h666, 1, 0, 3'd0);
    step();
    resetN = 1'b1;
    drive(0, 64'h0, 0, 0, 3'd0);
    chk_reset_state("mid-reset");
    step();
    chk("post-reset issue_valid", 64'(issue_valid), 64'd0);
    chk("post-reset busy_cnt", 64'(busy_cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
